data_mem_mmio: RTL and testbench
================================

// Module: data_mem_mmio
// PURPOSE
//  Responder side of the cpu data port: services dataAddr/writeData/we and returns readData.
//  Holds word RAM plus an MMIO window: free-running cycle counter and a byte TX FIFO
//  drained over a valid/ready stream (console/debug output).
//  readData is combinational because the single-cycle cpu consumes it in the same cycle.
// PARAMETERS
//  DEPTH_WORDS  256           RAM size in 32-bit words; power of 2
//  FIFO_DEPTH   8             TX FIFO entries; power of 2, 2..128
//  MMIO_BASE    32'h8000_0000 start of MMIO window; dataAddr >= MMIO_BASE selects MMIO
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  n_reset       in   1   synchronous reset, active-low
//  dataAddr      in   32  byte address from cpu
//  writeData     in   32  store data from cpu
//  we            in   1   store strobe; write committed at next rising clk
//  readData      out  32  combinational read data for dataAddr
//  tx_data       out  8   FIFO head byte
//  tx_valid      out  1   FIFO not empty
//  tx_ready      in   1   sink accepts tx_data when tx_valid & tx_ready at rising clk
//  misalign_err  out  1   sticky misaligned-store flag (only with MISALIGN_TRAP_EN)
// BEHAVIOUR
//  Reset (n_reset=0 at rising clk): FIFO empty, count=0, overflow=0, CYCLE=0,
//   tx_valid=0, misalign_err=0. RAM contents NOT cleared. Reset beats all other updates.
//  RAM (dataAddr < MMIO_BASE): word index dataAddr[log2(DEPTH_WORDS)+1:2]; upper bits
//   ignored (aliasing wrap). Read is zero-latency; store visible to reads next cycle.
//  MMIO map (offset = dataAddr - MMIO_BASE):
//   0x0 CYCLE  RW: +1 per cycle out of reset, wraps FFFF_FFFF->0; store loads writeData
//              (load beats increment; reads writeData next cycle, then increments).
//   0x4 TXDATA WO: store pushes writeData[7:0]; if full, byte dropped, overflow:=1. Reads 0.
//   0x8 STATUS   : bit0 full, bit1 empty, bit2 overflow (sticky), [15:8] count, rest 0.
//              Store with writeData[2]=1 clears overflow (W1C); other bits read-only.
//   other offsets: read 0, stores ignored.
//  FIFO: circular rd/wr pointers, count width log2(FIFO_DEPTH)+1.
//   tx_valid = !empty; tx_data = head; pop on tx_valid & tx_ready.
//   push then tx_valid high the following cycle (1-cycle latency, no bypass).
//   push+pop same cycle: both happen, count unchanged; when full, the push is accepted
//   (no overflow). When empty: push only; pop impossible (tx_valid=0).
//  Overflow set and W1C clear same cycle: set wins.
//  we=0: no state change except CYCLE increment and FIFO pop.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: misalign_err port present; store with dataAddr[1:0]!=0 is
//   suppressed (RAM/MMIO unchanged) and sets misalign_err; cleared only by reset.
//  Undefined: port absent; dataAddr[1:0] ignored, store hits the enclosing word.
// TESTING
//  1 reset; store 0x01FE @0x0; read @0x0 -> 0x01FE; read @4*DEPTH_WORDS -> 0x01FE (alias).
//  2 reset; idle 10 cycles; read CYCLE -> 10; store 0xFFFF_FFFE -> reads FFFF_FFFE,
//    FFFF_FFFF, 0 on successive cycles.
//  3 tx_ready=0; push 0x41..0x49 (9 bytes) -> STATUS=0x0000_0805 (count 8, full, ovf);
//    tx_ready=1 -> tx_data 0x41..0x48 one per cycle, then tx_valid=0, STATUS bit1=1.
//  4 full FIFO, tx_ready=1, push 0x50 -> count stays 8, overflow stays 0, 0x50 last out.
//  5 reset mid-drain: next cycle tx_valid=0, STATUS=0x0000_0002, RAM word @0x0 retained.
//  6 MISALIGN_TRAP_EN: store 0xDEAD @0x2 -> misalign_err=1, read @0x0 unchanged.

Source files
------------

// File: rtl/data_mem_mmio.sv
// CPU data-port responder: word RAM plus MMIO window (cycle counter, byte TX FIFO, status).
// Optional build macro MISALIGN_TRAP_EN adds misalign_err and suppresses misaligned stores.
module data_mem_mmio #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] dataAddr,
  input  logic [31:0] writeData,
  input  logic        we,
  output logic [31:0] readData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          ovf_q, ovf_d;

  logic          mmio_sel, sel_cycle, sel_tx, sel_status;
  logic [31:0]   mmio_off;
  logic [AW-1:0] ram_idx;
  logic          store, full, empty, pop, push_req, push, ovf_set;
  logic [31:0]   status;
  logic          unused_off;

  // MMIO registers are word-decoded; the low offset bits never select a register.
  assign mmio_sel   = dataAddr >= MMIO_BASE;
  assign mmio_off   = dataAddr - MMIO_BASE;
  assign sel_cycle  = mmio_sel && (mmio_off[31:2] == 30'd0);
  assign sel_tx     = mmio_sel && (mmio_off[31:2] == 30'd1);
  assign sel_status = mmio_sel && (mmio_off[31:2] == 30'd2);
  assign ram_idx    = dataAddr[AW+1:2];
  assign unused_off = ^mmio_off[1:0];

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  logic misaligned;
  assign misaligned   = dataAddr[1:0] != 2'b00;
  assign store        = we && !misaligned;
  assign misalign_err = misalign_q;

  always_ff @(posedge clk) begin
    if (!n_reset)                misalign_q <= 1'b0;
    else if (we && misaligned)   misalign_q <= 1'b1;
  end
`else
  assign store = we;
`endif

  assign full     = count_q == CW'(FIFO_DEPTH);
  assign empty    = count_q == '0;
  assign tx_valid = !empty;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign pop      = tx_valid && tx_ready;
  assign push_req = store && sel_tx;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  assign status = {16'h0, 8'(count_q), 5'h0, ovf_q, empty, full};

  always_comb begin
    readData = '0;
    if (!mmio_sel)       readData = ram_q[ram_idx];
    else if (sel_cycle)  readData = cycle_q;
    else if (sel_status) readData = status;
  end

  always_comb begin
    cycle_d  = (store && sel_cycle) ? writeData : cycle_q + 32'd1;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (store && sel_status && writeData[2]) ovf_d = 1'b0;
    if (ovf_set)                             ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cycle_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays carry no reset; reset only blocks writes in the reset cycle.
  always_ff @(posedge clk) begin
    if (n_reset && push) fifo_q[wr_ptr_q] <= writeData[7:0];
  end

  always_ff @(posedge clk) begin
    if (n_reset && store && !mmio_sel) ram_q[ram_idx] <= writeData;
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomized self-checking bench for data_mem_mmio against a queue/array reference model.
module tb_data_mem_mmio;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned FD    = 8;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        we = 1'b0, tx_ready = 1'b0;
  logic [31:0] readData;
  logic [7:0]  tx_data;
  logic        tx_valid;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  data_mem_mmio #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD), .MMIO_BASE(BASE)) dut (
    .clk(clk), .n_reset(n_reset), .dataAddr(addr), .writeData(wdata), .we(we),
    .readData(readData), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_err = 0;

  // reference model state
  logic [31:0] m_ram [DEPTH];
  logic [7:0]  q [$];
  logic [31:0] m_cyc;
  logic        m_ovf, m_mis;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int unsigned off;
    if (a < BASE) return m_ram[(a >> 2) % DEPTH];
    off = (a - BASE) >> 2;
    if (off == 0) return m_cyc;
    if (off == 2) return {16'h0, 8'(q.size()), 5'h0, m_ovf, q.size() == 0, q.size() == FD};
    return 32'h0;
  endfunction

  task automatic m_update();
    bit st, mm, full0, pp, ovfset;
    int unsigned off;
    if (!n_reset) begin
      q.delete(); m_cyc = 0; m_ovf = 0; m_mis = 0;
      return;
    end
    st = we;
`ifdef MISALIGN_TRAP_EN
    if (we && addr[1:0] != 2'b00) begin st = 0; m_mis = 1; end
`endif
    mm = addr >= BASE;
    off = (addr - BASE) >> 2;
    full0 = q.size() == FD;
    pp = q.size() > 0 && tx_ready;
    ovfset = 0;
    m_cyc = (st && mm && off == 0) ? wdata : m_cyc + 1;
    if (pp) void'(q.pop_front());
    if (st && mm && off == 1) begin
      if (!full0 || pp) q.push_back(wdata[7:0]);
      else ovfset = 1;
    end
    if (st && mm && off == 2 && wdata[2]) m_ovf = 0;
    if (ovfset) m_ovf = 1;
    if (st && !mm) m_ram[(addr >> 2) % DEPTH] = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic drive(input logic rst_n, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic rdy);
    n_reset = rst_n; addr = a; wdata = d; we = w; tx_ready = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b1, BASE + 32'h8, 32'h0, 1'b0, 1'b0); #2;
    n_cmp++; if (readData !== 32'h2) begin n_err++; $display("FAIL reset_status got=%h exp=%h", readData, 32'h2); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    addr = BASE; #1;
    n_cmp++; if (readData !== 32'h0) begin n_err++; $display("FAIL reset_cycle got=%h exp=0", readData); end
  endtask

  task automatic test_ram();
    do_reset();
    drive(1'b1, 32'h0, 32'h0000_01FE, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0); #2;
    n_cmp++; if (readData !== 32'h01FE) begin n_err++; $display("FAIL ram_read got=%h exp=%h", readData, 32'h01FE); end
    addr = 4 * DEPTH; #1;
    n_cmp++; if (readData !== 32'h01FE) begin n_err++; $display("FAIL ram_alias got=%h exp=%h", readData, 32'h01FE); end
  endtask

  task automatic test_cycle();
    logic [31:0] exp [3];
    exp[0] = 32'hFFFF_FFFE; exp[1] = 32'hFFFF_FFFF; exp[2] = 32'h0;
    do_reset();
    drive(1'b1, BASE, 32'h0, 1'b0, 1'b0);
    repeat (10) tick();
    n_cmp++; if (readData !== 32'd10) begin n_err++; $display("FAIL cycle_count got=%0d exp=10", readData); end
    drive(1'b1, BASE, 32'hFFFF_FFFE, 1'b1, 1'b0); tick();
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (readData !== exp[i]) begin n_err++; $display("FAIL cycle_wrap[%0d] got=%h exp=%h", i, readData, exp[i]); end
      tick();
    end
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, BASE + 32'h4, 32'h41 + i, 1'b1, 1'b0); tick();
    end
    drive(1'b1, BASE + 32'h8, 32'h0, 1'b0, 1'b0); #1;
    n_cmp++; if (readData !== 32'h0000_0805) begin n_err++; $display("FAIL ovf_status got=%h exp=%h", readData, 32'h805); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        n_err++; $display("FAIL drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
      tick();
    end
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || readData[1] !== 1'b1) begin
      n_err++; $display("FAIL drained got=%b/%h exp=0/empty", tx_valid, readData); end
    drive(1'b1, BASE + 32'h8, 32'h4, 1'b1, 1'b0); tick();
    we = 1'b0; #1;
    n_cmp++; if (readData !== 32'h2) begin n_err++; $display("FAIL w1c got=%h exp=%h", readData, 32'h2); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp [8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, BASE + 32'h4, 32'h41 + i, 1'b1, 1'b0); tick();
      exp[i] = 8'(8'h42 + i);
    end
    exp[7] = 8'h50;
    drive(1'b1, BASE + 32'h4, 32'h50, 1'b1, 1'b1); #1;
    n_cmp++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL pp_head got=%h exp=41", tx_data); end
    tick();
    drive(1'b1, BASE + 32'h8, 32'h0, 1'b0, 1'b0); #1;
    n_cmp++; if (readData !== 32'h0000_0801) begin n_err++; $display("FAIL pp_status got=%h exp=%h", readData, 32'h801); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
        n_err++; $display("FAIL pp_drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp[i]); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h0, 32'h0000_CAFE, 1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BASE + 32'h4, 32'h61 + i, 1'b1, 1'b0); tick();
    end
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b1); tick();
    do_reset();
    drive(1'b1, BASE + 32'h8, 32'h0, 1'b0, 1'b1); #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_tx_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (readData !== 32'h2) begin n_err++; $display("FAIL mid_status got=%h exp=%h", readData, 32'h2); end
    addr = 32'h0; #1;
    n_cmp++; if (readData !== 32'h0000_CAFE) begin n_err++; $display("FAIL mid_ram got=%h exp=%h", readData, 32'hCAFE); end
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign();
    do_reset();
    drive(1'b1, 32'h0, 32'h1234, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h2, 32'hDEAD, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0); #1;
    n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign_err got=%b exp=1", misalign_err); end
    n_cmp++; if (readData !== 32'h1234) begin n_err++; $display("FAIL misalign_ram got=%h exp=%h", readData, 32'h1234); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] a, e;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0); tick();
    end
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = $urandom & 32'h7FFF_FFFF;
        2:       a = BASE;
        3:       a = BASE + 32'h4;
        4:       a = BASE + 32'h8;
        default: a = BASE + $urandom_range(0, 63);
      endcase
      drive(($urandom_range(0, 63) != 0), a, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 3);
      #2;
      e = m_read(a);
      n_cmp++; if (readData !== e) begin n_err++; $display("FAIL rnd_read[%0d] addr=%h got=%h exp=%h", n, a, readData, e); end
      n_cmp++; if (tx_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, tx_valid, q.size() > 0); end
      if (q.size() > 0) begin
        n_cmp++; if (tx_data !== q[0]) begin n_err++; $display("FAIL rnd_data[%0d] got=%h exp=%h", n, tx_data, q[0]); end
      end
`ifdef MISALIGN_TRAP_EN
      n_cmp++; if (misalign_err !== m_mis) begin n_err++; $display("FAIL rnd_mis[%0d] got=%b exp=%b", n, misalign_err, m_mis); end
`endif
      tick();
    end
  endtask

  initial begin
    m_cyc = 0; m_ovf = 0; m_mis = 0;
    #1;
    test_reset();
    test_ram();
    test_cycle();
    test_fifo_overflow();
    test_push_pop_full();
    test_reset_mid();
`ifdef MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
